serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
// - Bit-serial binary subtractor: computes diff = a - b - borrow_in, LSB first,
//   one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
// - Counterpart to the combinational full-adder datapath: trades area for WIDTH
//   cycles of latency.
// - Sits behind a start/done handshake, so a controller can issue one operation
//   at a time.
// PARAMETERS
// - WIDTH  8  operand/result width in bits (WIDTH >= 2)
// PORTS
// - clk         in   1      single clock; all state updates on rising edge
// - rst_n       in   1      synchronous, active-low reset
// - start       in   1      request; accepted only in IDLE
// - a           in   WIDTH  minuend, sampled on the accepting edge
// - b           in   WIDTH  subtrahend, sampled on the accepting edge
// - borrow_in   in   1      initial borrow, sampled on the accepting edge
// - busy        out  1      high in RUN and DONE
// - done        out  1      one-cycle pulse; diff/borrow_out valid
// - diff        out  WIDTH  result, held until the next done
// - borrow_out  out  1      final borrow, 1 => (a - b - borrow_in) < 0 unsigned
// - ovf         out  1      only with SERIAL_SUB_OVF_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_n=0 at an edge):
//   - state=IDLE; busy, done, diff, borrow_out, ovf, counter and shift regs all 0.
//   - Reset mid-operation aborts; no done is produced for the aborted operation.
// - FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 loads A<=a, B<=b, br<=borrow_in, cnt<=0; next state RUN.
//     start=0 stays in IDLE.
//   - RUN: each edge:
//     - d = A[0]^B[0]^br
//     - br <= (~A[0]&B[0]) | (~(A[0]^B[0])&br)
//     - R <= {d, R[WIDTH-1:1]}; A and B shift right by 1; cnt++
//     - After the edge with cnt==WIDTH-1: diff<=final R, borrow_out<=final br,
//       next state DONE.
//   - DONE: done=1 for exactly this one cycle; next state IDLE unconditionally.
// - Handshake and latency:
//   - start is ignored in RUN and DONE; no queuing. Back-to-back starts:
//     one IDLE cycle minimum between operations.
//   - Latency: done=1 exactly WIDTH edges after the edge that accepted start.
//     Throughput: one operation per WIDTH+2 cycles.
// - Arithmetic: modulo 2^WIDTH. diff = (a - b - borrow_in) mod 2^WIDTH.
//   borrow_out is the unsigned borrow from the MSB.
// - Boundaries:
//   - a==b with borrow_in=1 -> all ones, borrow_out=1.
//   - a=0, b=0, borrow_in=0 -> 0, borrow_out=0.
//   - Operand inputs may change freely while busy; only the values on the
//     accepting edge matter.
// - diff and borrow_out change only on entry to DONE, or on reset.
// CONFIGURATION
// - SERIAL_SUB_OVF_EN defined:
//   - adds output ovf, registered with diff on entry to DONE.
//   - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the sampled
//     operands: two's-complement overflow of a - b.
//   - borrow_in is excluded from the sign test; the full result is still used.
// - SERIAL_SUB_OVF_EN undefined:
//   - ovf port and its logic are absent.
//   - All other behaviour is identical.
// TESTING (WIDTH=8)
// - a=0x5A, b=0x23, borrow_in=0, start pulse -> busy next cycle; done 8 edges
//   later; diff=0x37, borrow_out=0.
// - a=0x10, b=0x20, borrow_in=0 -> diff=0xF0, borrow_out=1.
// - a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1.
//   a=0xFF, b=0xFF, borrow_in=0 -> diff=0x00, borrow_out=0.
// - start held high throughout; operands changed to 0xAA/0x55 while busy ->
//   first result unchanged; second operation accepted only after return to IDLE.
// - rst_n=0 for one edge at RUN cycle 4 -> busy=0, done=0, diff=0 next cycle;
//   no done for the aborted operation; a new start completes normally.
// - SERIAL_SUB_OVF_EN:
//   - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
//   - a=0x7F, b=0xFF -> diff=0x80, ovf=1, borrow_out=1.
//   - a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor, diff = a - b - borrow_in (mod 2^WIDTH),
// LSB first, one full-subtractor step per clock, behind a start/done handshake.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        request, accepted only when idle
//   a, b         minuend / subtrahend, sampled on the accepting edge
//   borrow_in    initial borrow, sampled on the accepting edge
//   busy         high while an operation is running or completing
//   done         one-cycle pulse, diff/borrow_out valid
//   diff         result, held until the next done
//   borrow_out   final unsigned borrow from the MSB
//   ovf          two's-complement overflow of a - b (only with SERIAL_SUB_OVF_EN)
//
// Build option: define SERIAL_SUB_OVF_EN to add the ovf output.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_nxt;
    logic [WIDTH-1:0]   a_q, a_nxt;
    logic [WIDTH-1:0]   b_q, b_nxt;
    // Holds the WIDTH-1 result bits already produced; the last bit goes straight to diff.
    logic [WIDTH-2:0]   r_q, r_nxt;
    logic [WIDTH-1:0]   r_full;
    logic               br_q, br_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [WIDTH-1:0]   diff_nxt;
    logic               borrow_out_nxt;
    logic               d_bit;
    logic               br_step;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_nxt;
    logic               b_msb_q, b_msb_nxt;
    logic               ovf_nxt;
`endif

    // Next-state and datapath logic
    always_comb begin
        state_nxt      = state_q;
        a_nxt          = a_q;
        b_nxt          = b_q;
        r_nxt          = r_q;
        br_nxt         = br_q;
        cnt_nxt        = cnt_q;
        diff_nxt       = diff;
        borrow_out_nxt = borrow_out;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_nxt      = a_msb_q;
        b_msb_nxt      = b_msb_q;
        ovf_nxt        = ovf;
`endif
        // Full-subtractor cell on the current LSBs
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_step = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        r_full  = {d_bit, r_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    br_nxt    = borrow_in;
                    cnt_nxt   = '0;
                    state_nxt = S_RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_nxt = a[WIDTH-1];
                    b_msb_nxt = b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                a_nxt   = {1'b0, a_q[WIDTH-1:1]};
                b_nxt   = {1'b0, b_q[WIDTH-1:1]};
                r_nxt   = r_full[WIDTH-1:1];
                br_nxt  = br_step;
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_nxt       = r_full;
                    borrow_out_nxt = br_step;
                    state_nxt      = S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // d_bit is the result MSB on this final step
                    ovf_nxt = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            br_q       <= 1'b0;
            cnt_q      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            state_q    <= state_nxt;
            a_q        <= a_nxt;
            b_q        <= b_nxt;
            r_q        <= r_nxt;
            br_q       <= br_nxt;
            cnt_q      <= cnt_nxt;
            diff       <= diff_nxt;
            borrow_out <= borrow_out_nxt;
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q    <= a_msb_nxt;
            b_msb_q    <= b_msb_nxt;
            ovf        <= ovf_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed table, handshake
// corner sequences, reset abort and randomized operations against an arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_bo;
        logic         exp_ovf;
    } vec_t;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] last_diff   = '0;
    logic         last_bo     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; borrow when the true result is negative
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bin);
        int r;
        logic [W-1:0] dd;
        r  = int'(x) - int'(y) - (bin ? 1 : 0);
        dd = W'(r & ((1 << W) - 1));
        return {(r < 0), dd};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [W-1:0] dd);
        return (x[W-1] != y[W-1]) && (dd[W-1] != x[W-1]);
    endfunction

    // Waits for done from the negedge after the accepting edge; lat = edges taken
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < int'(W) + 4) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
            if (lat == int'(W) / 2)
                check("diff_held", 32'({borrow_out, diff}), 32'({last_bo, last_diff}));
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
        else check("busy_in_done", 32'(busy), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin);
        int         lat;
        logic [W:0] r;
        @(negedge clk);
        a = x; b = y; borrow_in = bin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(lat);
        r = ref_sub(x, y, bin);
        check("latency", 32'(lat), 32'(W));
        check("diff", 32'(diff), 32'(r[W-1:0]));
        check("borrow_out", 32'(borrow_out), 32'(r[W]));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(ref_ovf(x, y, r[W-1:0])));
`endif
        last_diff = r[W-1:0];
        last_bo   = r[W];
    endtask

    vec_t tbl[10];

    initial begin
        int   lat;
        logic seen;

        tbl[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
        tbl[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'h37, 8'h37, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[7] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        tbl[8] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[9] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;

        // Directed table against hand-computed expectations
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin);
            check("tbl_diff", 32'(diff), 32'(tbl[i].exp_diff));
            check("tbl_borrow", 32'(borrow_out), 32'(tbl[i].exp_bo));
`ifdef SERIAL_SUB_OVF_EN
            check("tbl_ovf", 32'(ovf), 32'(tbl[i].exp_ovf));
`endif
        end

        // start held high; operands change while busy
        @(negedge clk);
        a = 8'h5A; b = 8'h23; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55;
        check("held_busy", 32'(busy), 32'd1);
        wait_done(lat);
        check("held_lat1", 32'(lat), 32'(W));
        check("held_diff1", 32'(diff), 32'h37);
        check("held_bo1", 32'(borrow_out), 32'd0);
        last_diff = 8'h37; last_bo = 1'b0;
        @(negedge clk);
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_done", 32'(done), 32'd0);
        @(negedge clk);
        check("held_accept2", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(lat);
        check("held_lat2", 32'(lat), 32'(W));
        check("held_diff2", 32'(diff), 32'h55);
        check("held_bo2", 32'(borrow_out), 32'd0);
        last_diff = 8'h55; last_bo = 1'b0;

        // Reset in the middle of an operation aborts it
        @(negedge clk);
        a = 8'h33; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bo", 32'(borrow_out), 32'd0);
        seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        last_diff = '0; last_bo = 1'b0;
        run_op(8'h5A, 8'h23, 1'b0);

        // Randomized operations
        for (int i = 0; i < 40; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
